alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//   Upstream feeder for the 4-bit combinational mode ALU (add/sub/mul/and). Buffers commands
//   {mode,a,b} in a DEPTH-entry FIFO, drives the FIFO head onto the ALU inputs, and registers
//   alu_result into a response slot with valid/ready flow control. Order-preserving; no reordering.
// PARAMETERS
//   DEPTH  4  command FIFO entries; power of two, >= 2
//   W      4  operand/result width; must match the ALU
// PORTS
//   clk          in   1                  rising-edge clock
//   rst          in   1                  synchronous active-high reset
//   flush        in   1                  sync clear of FIFO and response slot
//   cmd_valid    in   1                  command offered
//   cmd_ready    out  1                  command slot free
//   cmd_mode     in   2                  00 add, 01 sub, 10 mul, 11 and
//   cmd_a        in   W                  operand a
//   cmd_b        in   W                  operand b
//   alu_mode     out  2                  to ALU mode
//   alu_a        out  W                  to ALU a
//   alu_b        out  W                  to ALU b
//   alu_result   in   W                  from ALU result (combinational from alu_*)
//   rsp_valid    out  1                  response held
//   rsp_ready    in   1                  consumer accepts response
//   rsp_result   out  W                  captured ALU result
//   rsp_mode     out  2                  mode that produced rsp_result
//   fifo_count   out  $clog2(DEPTH)+1    commands buffered, 0..DEPTH
//   rsp_total    out  8                  only with ALU_CMD_SEQ_STATS_EN
// BEHAVIOUR
//   - Reset (rst=1 at edge): pointers, fifo_count, rsp_valid, rsp_result, rsp_mode, rsp_total = 0.
//   - alu_mode/alu_a/alu_b = FIFO head when fifo_count>0, else all zero; driven from registers only.
//   - cmd_ready = (fifo_count < DEPTH) && !flush; registered-state only, no path from rsp_ready.
//   - Push when cmd_valid && cmd_ready. Full FIFO: no push even if a pop occurs same cycle.
//   - Pop/capture when fifo_count>0 && (!rsp_valid || rsp_ready): rsp_result<=alu_result,
//     rsp_mode<=head mode, rsp_valid<=1. Else if rsp_valid && rsp_ready: rsp_valid<=0.
//   - Simultaneous push+pop: fifo_count unchanged; pointers both advance, wrap modulo DEPTH.
//   - rsp_result/rsp_mode stable while rsp_valid && !rsp_ready.
//   - Latency: command accepted in cycle N into empty block -> rsp_valid high in cycle N+2.
//   - Throughput: one response per cycle with rsp_ready held high.
//   - Arithmetic done by ALU; result is W bits, wraps (9+8=1, 4*4=0, 2-3=15).
//   - flush=1 at edge: fifo_count=0, pointers=0, rsp_valid=0; concurrent push dropped;
//     rsp_total unchanged. rst has priority over flush.
//   - Reset mid-operation: all buffered commands and pending response discarded, no output.
// CONFIGURATION
//   ALU_CMD_SEQ_STATS_EN defined: port rsp_total present; increments on each rsp_valid&&rsp_ready
//     handshake, saturates at 255, cleared only by rst.
//   Not defined: rsp_total port and counter absent; all other behaviour identical.
// TESTING
//   1. rst 2 cycles -> all outputs 0, cmd_ready=1, fifo_count=0, alu_* = 0.
//   2. push {00,9,8}, rsp_ready=1 -> rsp_valid 2 cycles later, rsp_result=1, rsp_mode=00.
//   3. rsp_ready=0, push 5 cmds (DEPTH=4) -> one captured, 4 buffered, cmd_ready=0 at
//      fifo_count=4; 6th offer stalls; release rsp_ready -> results in order, one per cycle.
//   4. back-to-back {10,3,5},{10,4,4},{01,2,3},{11,12,10} -> 15,0,15,8 in order.
//   5. fifo_count=3, rsp_valid=1, assert flush with cmd_valid=1 -> next cycle fifo_count=0,
//      rsp_valid=0, flushed command never appears.
//   6. STATS_EN: 260 handshakes -> rsp_total=255; flush keeps it; rst clears it to 0.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Purpose:
//   Feeds a 4-bit combinational mode ALU (add/sub/mul/and). Commands
//   {mode,a,b} are buffered in a DEPTH-entry FIFO. The FIFO head is presented
//   on the ALU inputs, and the ALU result is registered into a single response
//   slot with valid/ready flow control. Commands stay in order.
//
// Parameters:
//   DEPTH  command FIFO entries (power of two, >= 2)
//   W      operand/result width (must match the ALU)
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   flush                synchronous clear of FIFO and response slot
//   cmd_valid/cmd_ready  command handshake; cmd_mode/cmd_a/cmd_b payload
//   alu_mode/alu_a/alu_b FIFO head towards the ALU (zero when empty)
//   alu_result           combinational ALU result for the current head
//   rsp_valid/rsp_ready  response handshake; rsp_result/rsp_mode payload
//   fifo_count           number of buffered commands, 0..DEPTH
//   rsp_total            handshake counter, saturating at 255
//                        (present only with ALU_CMD_SEQ_STATS_EN defined)
//
// Build option:
//   ALU_CMD_SEQ_STATS_EN  adds the rsp_total port and its counter.
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int W     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_mode,
    input  logic [W-1:0]               cmd_a,
    input  logic [W-1:0]               cmd_b,
    output logic [1:0]                 alu_mode,
    output logic [W-1:0]               alu_a,
    output logic [W-1:0]               alu_b,
    input  logic [W-1:0]               alu_result,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [W-1:0]               rsp_result,
    output logic [1:0]                 rsp_mode,
    output logic [$clog2(DEPTH):0]     fifo_count
`ifdef ALU_CMD_SEQ_STATS_EN
    ,
    output logic [7:0]                 rsp_total
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // FIFO storage (data only, no reset needed)
    logic [1:0]    r_fifo_mode [DEPTH];
    logic [W-1:0]  r_fifo_a    [DEPTH];
    logic [W-1:0]  r_fifo_b    [DEPTH];

    // Control state
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_rsp_valid;
    logic [W-1:0]  r_rsp_result;
    logic [1:0]    r_rsp_mode;

    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    assign w_empty   = (r_count == '0);
    // Depends only on registered state and flush, never on rsp_ready, so a
    // full FIFO refuses a push even in a cycle where it also pops.
    assign cmd_ready = (r_count < FULL) && !flush;
    assign w_push    = cmd_valid && cmd_ready;
    // The response slot is free if empty or being drained this cycle.
    assign w_pop     = !w_empty && (!r_rsp_valid || rsp_ready);

    // Head is forced to zero when empty so the ALU never sees stale entries.
    assign alu_mode  = w_empty ? 2'b00 : r_fifo_mode[r_rptr];
    assign alu_a     = w_empty ? '0    : r_fifo_a[r_rptr];
    assign alu_b     = w_empty ? '0    : r_fifo_b[r_rptr];

    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign rsp_mode   = r_rsp_mode;
    assign fifo_count = r_count;

    // Command write stage
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mode[r_wptr] <= cmd_mode;
            r_fifo_a[r_wptr]    <= cmd_a;
            r_fifo_b[r_wptr]    <= cmd_b;
        end
    end

    // Pointer/count control and response capture stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_mode   <= 2'b00;
        end else if (flush) begin
            // Payload registers are left alone; rsp_valid=0 hides them.
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_rsp_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_pop) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_result <= alu_result;
                r_rsp_mode   <= alu_mode;
            end else if (r_rsp_valid && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_CMD_SEQ_STATS_EN
    logic [7:0] r_rsp_total;

    assign rsp_total = r_rsp_total;

    // Handshake statistics stage; a flush cycle leaves the count untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_total <= 8'd0;
        end else if (!flush && r_rsp_valid && rsp_ready && (r_rsp_total != 8'hFF)) begin
            r_rsp_total <= r_rsp_total + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int W     = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_mode;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic [1:0]   alu_mode;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_result;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic [1:0]   rsp_mode;
    logic [2:0]   fifo_count;
`ifdef ALU_CMD_SEQ_STATS_EN
    logic [7:0]   rsp_total;
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    // External combinational ALU
    logic [7:0] w_prod;
    assign w_prod = {4'd0, alu_a} * {4'd0, alu_b};
    always_comb begin
        alu_result = '0;
        case (alu_mode)
            2'b00: alu_result = alu_a + alu_b;
            2'b01: alu_result = alu_a - alu_b;
            2'b10: alu_result = w_prod[3:0];
            2'b11: alu_result = alu_a & alu_b;
            default: alu_result = '0;
        endcase
    end

    alu_cmd_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_mode   (alu_mode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_mode   (rsp_mode),
        .fifo_count (fifo_count)
`ifdef ALU_CMD_SEQ_STATS_EN
        ,
        .rsp_total  (rsp_total)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] m, input logic [3:0] a, input logic [3:0] b);
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_a     = a;
        cmd_b     = b;
    endtask

    task automatic rsp_chk(input string tag, input logic [3:0] res, input logic [1:0] m);
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_result"}, 32'(rsp_result), 32'(res));
        check({tag, "_mode"}, 32'(rsp_mode), 32'(m));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; cmd_valid = 1'b0;
        cmd_mode = 2'b00; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;

        // 1: reset
        step(); step();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_result", 32'(rsp_result), 32'd0);
        check("rst_rsp_mode", 32'(rsp_mode), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_mode", 32'(alu_mode), 32'd0);
        rst = 1'b0;

        // 2: single add 9+8 wraps to 1, response two cycles after acceptance
        rsp_ready = 1'b1;
        offer(2'b00, 4'd9, 4'd8);
        step();
        cmd_valid = 1'b0;
        check("t2_count1", 32'(fifo_count), 32'd1);
        check("t2_no_rsp_yet", 32'(rsp_valid), 32'd0);
        check("t2_alu_a", 32'(alu_a), 32'd9);
        check("t2_alu_b", 32'(alu_b), 32'd8);
        step();
        rsp_chk("t2_rsp", 4'd1, 2'b00);
        check("t2_count0", 32'(fifo_count), 32'd0);
        step();
        check("t2_drained", 32'(rsp_valid), 32'd0);

        // 3: backpressure, fill FIFO, stall, then drain in order
        rsp_ready = 1'b0;
        offer(2'b00, 4'd1, 4'd2);  step();   // 3
        offer(2'b01, 4'd7, 4'd2);  step();   // 5
        offer(2'b10, 4'd3, 4'd3);  step();   // 9
        offer(2'b11, 4'd6, 4'd3);  step();   // 2
        offer(2'b00, 4'd15, 4'd1); step();   // 0
        check("t3_full_count", 32'(fifo_count), 32'd4);
        check("t3_full_ready", 32'(cmd_ready), 32'd0);
        rsp_chk("t3_held", 4'd3, 2'b00);
        offer(2'b00, 4'd2, 4'd2);            // 4, stalls while full
        step(); step();
        check("t3_stall_count", 32'(fifo_count), 32'd4);
        rsp_chk("t3_stable", 4'd3, 2'b00);
        rsp_ready = 1'b1;
        step();
        rsp_chk("t3_r1", 4'd5, 2'b01);
        check("t3_full_no_push", 32'(fifo_count), 32'd3);
        step();
        cmd_valid = 1'b0;
        rsp_chk("t3_r2", 4'd9, 2'b10);
        check("t3_push_pop_count", 32'(fifo_count), 32'd3);
        step(); rsp_chk("t3_r3", 4'd2, 2'b11);
        step(); rsp_chk("t3_r4", 4'd0, 2'b00);
        step(); rsp_chk("t3_r5", 4'd4, 2'b00);
        check("t3_empty", 32'(fifo_count), 32'd0);
        step();
        check("t3_done", 32'(rsp_valid), 32'd0);

        // 4: back-to-back throughput with wrapping arithmetic
        offer(2'b10, 4'd3, 4'd5);   step();
        offer(2'b10, 4'd4, 4'd4);   step(); rsp_chk("t4_r1", 4'd15, 2'b10);
        offer(2'b01, 4'd2, 4'd3);   step(); rsp_chk("t4_r2", 4'd0, 2'b10);
        offer(2'b11, 4'd12, 4'd10); step(); rsp_chk("t4_r3", 4'd15, 2'b01);
        cmd_valid = 1'b0;           step(); rsp_chk("t4_r4", 4'd8, 2'b11);
        step();
        check("t4_done", 32'(rsp_valid), 32'd0);

        // 5: flush with pending response and concurrent push
        rsp_ready = 1'b0;
        offer(2'b00, 4'd1, 4'd1); step();
        offer(2'b00, 4'd2, 4'd2); step();
        offer(2'b00, 4'd3, 4'd3); step();
        offer(2'b00, 4'd4, 4'd4); step();
        check("t5_pre_count", 32'(fifo_count), 32'd3);
        check("t5_pre_valid", 32'(rsp_valid), 32'd1);
        flush = 1'b1;
        offer(2'b00, 4'd5, 4'd5);
        #1;
        check("t5_ready_low", 32'(cmd_ready), 32'd0);
        step();
        flush = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
        check("t5_count0", 32'(fifo_count), 32'd0);
        check("t5_valid0", 32'(rsp_valid), 32'd0);
        check("t5_alu_a0", 32'(alu_a), 32'd0);
        step(); check("t5_quiet1", 32'(rsp_valid), 32'd0);
        step(); check("t5_quiet2", 32'(rsp_valid), 32'd0);
        offer(2'b01, 4'd2, 4'd3); step();
        cmd_valid = 1'b0;         step();
        rsp_chk("t5_recover", 4'd15, 2'b01);
        step();

        // Reset mid-operation discards buffered work
        rsp_ready = 1'b0;
        offer(2'b00, 4'd6, 4'd6); step();
        offer(2'b00, 4'd7, 4'd7); step();
        cmd_valid = 1'b0;
        rst = 1'b1; step();
        rst = 1'b0; rsp_ready = 1'b1;
        check("rstmid_count", 32'(fifo_count), 32'd0);
        check("rstmid_valid", 32'(rsp_valid), 32'd0);
        step(); step();
        check("rstmid_quiet", 32'(rsp_valid), 32'd0);

`ifdef ALU_CMD_SEQ_STATS_EN
        // 6: saturating handshake counter
        check("t6_start", 32'(rsp_total), 32'd0);
        offer(2'b00, 4'd1, 4'd1);
        for (int i = 0; i < 261; i++) step();
        cmd_valid = 1'b0;
        step(); step();
        check("t6_saturated", 32'(rsp_total), 32'd255);
        flush = 1'b1; step(); flush = 1'b0;
        check("t6_flush_keeps", 32'(rsp_total), 32'd255);
        rst = 1'b1; step(); rst = 1'b0;
        check("t6_rst_clears", 32'(rsp_total), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
